priority_encoder: RTL and testbench
===================================

# priority_encoder

Registered two-sided priority encoder. For each valid input word it isolates the most-significant set bit and the least-significant set bit, each as a one-hot mask of the input width. It is a pipeline leaf block: one input word per cycle, results one cycle later, with no backpressure.

## Interface
- `WIDTH`, default 4: input and output word width in bits, ≥ 1.

- `clk_i` input 1: clock; all state updates on the rising edge.
- `srst_i` input 1: reset, synchronous and active-high.
- `data_i` input WIDTH: word to encode; sampled only when `data_val_i` = 1.
- `data_val_i` input 1: input-valid qualifier.
- `data_left_o` output WIDTH: one-hot mask of the highest set bit of the sampled word; zero if the word is zero.
- `data_right_o` output WIDTH: one-hot mask of the lowest set bit of the sampled word; zero if the word is zero.
- `data_val_o` output 1: result-valid strobe.

## Operation
- On a rising edge with `srst_i` = 1:
  - `data_left_o`, `data_right_o` and `data_val_o` are cleared to 0.
  - Reset overrides a simultaneous `data_val_i`.
- On a rising edge with `srst_i` = 0 and `data_val_i` = 1:
  - `data_left_o` ← `1 << i`, where i is the highest index with `data_i[i]` = 1.
  - `data_right_o` ← `1 << j`, where j is the lowest index with `data_i[j]` = 1.
  - `data_val_o` ← 1.
- On a rising edge with `srst_i` = 0 and `data_val_i` = 0:
  - `data_val_o` ← 0.
  - `data_left_o` and `data_right_o` hold their last values.
- Zero input word: both masks are all zeros and `data_val_o` still goes to 1. A zero word is a valid result, not an error.
- Single set bit: `data_left_o` and `data_right_o` are identical and equal to `data_i`.
- All bits set: `data_left_o` = `1 << (WIDTH-1)` and `data_right_o` = 1.
- `data_i` is ignored when `data_val_i` = 0; its value is don't-care.
- No internal state beyond the output registers. Every accepted input is independent of earlier ones.

## Timing
- Latency is exactly 1 cycle. Input sampled at edge N appears on all outputs right after edge N, and `data_val_o` is high for the cycle between edges N and N+1.
- Throughput is one word per cycle. Back-to-back `data_val_i` gives back-to-back `data_val_o`, with results in input order.
- `data_val_o` is a one-cycle strobe per accepted input. It is never stretched.
- Reset asserted mid-stream: outputs are zero after that edge, and no result from an input presented in the reset cycle is ever produced.
- All outputs come directly from flops. There is no combinational path from inputs to outputs.

## Structure
- No shared package is needed; the block has no typedefs or enums.
- One natural sub-module, `priority_encoder_onehot_lsb`:
  - Parameter `WIDTH`; input `data`; output `onehot`.
  - Purely combinational; isolates the lowest set bit, e.g. `data & (~data + 1)` or a loop.
- The top instantiates it twice:
  - LSB side: `data_i` directly.
  - MSB side: `data_i` bit-reversed, with the result bit-reversed back.
- The top holds the three output registers and the reset/valid logic.

## Test plan
- Reset, then `data_val_i` = 0 for 3 cycles: all outputs stay 0, `data_val_o` never asserts.
- `data_i` = 0000 with valid for one cycle: next cycle `data_val_o` = 1, left = 0000, right = 0000; the following cycle `data_val_o` = 0.
- One-hot inputs 1000, 0100, 0010, 0001 each with one valid pulse: left = right = input, `data_val_o` = 1 one cycle after each.
- 1111 → left 1000, right 0001. 0110 → left 0100, right 0010. 1010 → left 1000, right 0010.
- Back-to-back valid 0011, 1100, 0101: results 0010/0001, 1000/0100, 0100/0001 on consecutive cycles with `data_val_o` held high. Then assert `srst_i` together with valid 1111: outputs are 0 after that edge.
- 100+ random words with random valid gaps, compared against a reference model:
  - Left mask: scan from the MSB for the first set bit.
  - Right mask: scan from the LSB for the first set bit.
  - Check the outputs and strobe one cycle after each accepted input.
  - Repeat the run with `WIDTH` = 1 and `WIDTH` = 8.

Source files
------------

// File: rtl/priority_encoder_onehot_lsb.sv
// Combinational lowest-set-bit isolator: returns a one-hot mask of the
// least-significant 1 in data, or all zeros when data is zero.
module priority_encoder_onehot_lsb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] onehot
);

  // Two's complement of data flips every bit above the lowest 1 and keeps
  // that 1, so the AND leaves only the lowest set bit. Zero maps to zero.
  assign onehot = data & (~data + WIDTH'(1));

endmodule

// File: rtl/priority_encoder.sv
// Registered two-sided priority encoder: one-hot masks of the highest and
// lowest set bits of each valid input word, one cycle after acceptance.
module priority_encoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic [WIDTH-1:0] data_left_o,
  output logic [WIDTH-1:0] data_right_o,
  output logic             data_val_o
);

  logic [WIDTH-1:0] data_rev;
  logic [WIDTH-1:0] left_rev;
  logic [WIDTH-1:0] left_next;
  logic [WIDTH-1:0] right_next;

  logic [WIDTH-1:0] data_left_reg;
  logic [WIDTH-1:0] data_right_reg;
  logic             data_val_reg;

  // The highest set bit is the lowest set bit of the bit-reversed word, so
  // the same isolator serves both sides; only wiring differs.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign data_rev[gi]  = data_i[WIDTH-1-gi];
      assign left_next[gi] = left_rev[WIDTH-1-gi];
    end
  endgenerate

  priority_encoder_onehot_lsb #(
    .WIDTH (WIDTH)
  ) u_lsb_right (
    .data   (data_i),
    .onehot (right_next)
  );

  priority_encoder_onehot_lsb #(
    .WIDTH (WIDTH)
  ) u_lsb_left (
    .data   (data_rev),
    .onehot (left_rev)
  );

  // Output registers: reset clears all, valid loads masks, idle holds masks
  // and drops the strobe so it never stretches.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_left_reg  <= '0;
      data_right_reg <= '0;
      data_val_reg   <= 1'b0;
    end else begin
      data_val_reg <= data_val_i;
      if (data_val_i) begin
        data_left_reg  <= left_next;
        data_right_reg <= right_next;
      end
    end
  end

  assign data_left_o  = data_left_reg;
  assign data_right_o = data_right_reg;
  assign data_val_o   = data_val_reg;

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder at WIDTH 4, 1 and 8, with a
// scan-based reference model checked every cycle plus literal expectations.
module tb_priority_encoder;

  logic clk = 1'b0;
  logic srst = 1'b0;

  logic [3:0] d4 = '0;
  logic       v4 = 1'b0;
  logic [0:0] d1 = '0;
  logic       v1 = 1'b0;
  logic [7:0] d8 = '0;
  logic       v8 = 1'b0;

  logic [3:0] left4, right4;
  logic       val4;
  logic [0:0] left1, right1;
  logic       val1;
  logic [7:0] left8, right8;
  logic       val8;

  int total  = 0;
  int passed = 0;
  bit model_on = 1'b0;

  // Reference expectations, zero-extended to 8 bits for every instance.
  logic [7:0] m_left [3];
  logic [7:0] m_right[3];
  logic       m_val  [3];

  always #5 clk = ~clk;

  priority_encoder #(.WIDTH(4)) dut4 (
    .clk_i(clk), .srst_i(srst), .data_i(d4), .data_val_i(v4),
    .data_left_o(left4), .data_right_o(right4), .data_val_o(val4)
  );

  priority_encoder #(.WIDTH(1)) dut1 (
    .clk_i(clk), .srst_i(srst), .data_i(d1), .data_val_i(v1),
    .data_left_o(left1), .data_right_o(right1), .data_val_o(val1)
  );

  priority_encoder #(.WIDTH(8)) dut8 (
    .clk_i(clk), .srst_i(srst), .data_i(d8), .data_val_i(v8),
    .data_left_o(left8), .data_right_o(right8), .data_val_o(val8)
  );

  // Scan from the MSB down for the first set bit.
  function automatic logic [7:0] msb_mask(input logic [7:0] d, input int w);
    logic [7:0] one = 8'd1;
    for (int i = w - 1; i >= 0; i--)
      if (d[i]) return one << i;
    return 8'd0;
  endfunction

  // Scan from the LSB up for the first set bit.
  function automatic logic [7:0] lsb_mask(input logic [7:0] d, input int w);
    logic [7:0] one = 8'd1;
    for (int i = 0; i < w; i++)
      if (d[i]) return one << i;
    return 8'd0;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Model update on each rising edge from the stable inputs.
  always @(posedge clk) begin
    logic [7:0] dd [3];
    logic       vv [3];
    int         ww [3];
    dd[0] = {4'b0, d4}; vv[0] = v4; ww[0] = 4;
    dd[1] = {7'b0, d1}; vv[1] = v1; ww[1] = 1;
    dd[2] = d8;         vv[2] = v8; ww[2] = 8;
    for (int k = 0; k < 3; k++) begin
      if (srst) begin
        m_left[k] = '0; m_right[k] = '0; m_val[k] = 1'b0;
      end else begin
        m_val[k] = vv[k];
        if (vv[k]) begin
          m_left[k]  = msb_mask(dd[k], ww[k]);
          m_right[k] = lsb_mask(dd[k], ww[k]);
        end
      end
    end
  end

  // Compare every DUT against the model on each falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("w4_left",  {4'b0, left4},  m_left[0]);
      check("w4_right", {4'b0, right4}, m_right[0]);
      check("w4_val",   {7'b0, val4},   {7'b0, m_val[0]});
      check("w1_left",  {7'b0, left1},  m_left[1]);
      check("w1_right", {7'b0, right1}, m_right[1]);
      check("w1_val",   {7'b0, val1},   {7'b0, m_val[1]});
      check("w8_left",  left8,  m_left[2]);
      check("w8_right", right8, m_right[2]);
      check("w8_val",   {7'b0, val8},   {7'b0, m_val[2]});
      $display("cycle t=%0t w4 %b/%b v%b w1 %b/%b v%b w8 %b/%b v%b", $time,
               left4, right4, val4, left1, right1, val1, left8, right8, val8);
    end
  end

  // Drive the WIDTH-4 instance for one cycle, return at the next falling edge.
  task automatic step4(input logic [3:0] d, input logic v, input logic r = 1'b0);
    d4 = d; v4 = v; srst = r;
    v1 = 1'b0; v8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic lit4(input string name, input logic [3:0] l, input logic [3:0] r, input logic v);
    check({name, "_left"},  {4'b0, left4},  {4'b0, l});
    check({name, "_right"}, {4'b0, right4}, {4'b0, r});
    check({name, "_val"},   {7'b0, val4},   {7'b0, v});
  endtask

  initial begin
    logic [3:0] onehots [4];
    onehots[0] = 4'b1000; onehots[1] = 4'b0100;
    onehots[2] = 4'b0010; onehots[3] = 4'b0001;

    // Reset, then idle for three cycles.
    step4(4'b1111, 1'b1, 1'b1);
    model_on = 1'b1;
    lit4("reset", 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step4(4'($urandom), 1'b0);
      lit4("idle", 4'b0000, 4'b0000, 1'b0);
    end

    // Zero word is a valid result.
    step4(4'b0000, 1'b1);
    lit4("zero", 4'b0000, 4'b0000, 1'b1);
    step4(4'b1111, 1'b0);
    lit4("zero_after", 4'b0000, 4'b0000, 1'b0);

    // One-hot inputs, each as an isolated pulse.
    for (int i = 0; i < 4; i++) begin
      step4(onehots[i], 1'b1);
      lit4("onehot", onehots[i], onehots[i], 1'b1);
      step4(4'b0000, 1'b0);
      lit4("onehot_hold", onehots[i], onehots[i], 1'b0);
    end

    step4(4'b1111, 1'b1); lit4("all_ones", 4'b1000, 4'b0001, 1'b1);
    step4(4'b0110, 1'b1); lit4("p0110",    4'b0100, 4'b0010, 1'b1);
    step4(4'b1010, 1'b1); lit4("p1010",    4'b1000, 4'b0010, 1'b1);

    // Back-to-back stream then reset colliding with a valid word.
    step4(4'b0011, 1'b1); lit4("b2b0", 4'b0010, 4'b0001, 1'b1);
    step4(4'b1100, 1'b1); lit4("b2b1", 4'b1000, 4'b0100, 1'b1);
    step4(4'b0101, 1'b1); lit4("b2b2", 4'b0100, 4'b0001, 1'b1);
    step4(4'b1111, 1'b1, 1'b1); lit4("rst_mid", 4'b0000, 4'b0000, 1'b0);
    step4(4'b0000, 1'b0); lit4("rst_after", 4'b0000, 4'b0000, 1'b0);

    // Pin the model itself with hand-computed values.
    check("model_msb", msb_mask(8'b0010_1100, 8), 8'b0010_0000);
    check("model_lsb", lsb_mask(8'b0010_1100, 8), 8'b0000_0100);
    check("model_w1",  msb_mask(8'b0000_0001, 1), 8'b0000_0001);

    // Random words with random gaps on all three widths, rare resets.
    for (int n = 0; n < 300; n++) begin
      d4 = 4'($urandom); v4 = ($urandom_range(0, 2) != 0);
      d1 = 1'($urandom); v1 = ($urandom_range(0, 2) != 0);
      d8 = 8'($urandom); v8 = ($urandom_range(0, 2) != 0);
      srst = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    srst = 1'b0; v4 = 1'b0; v1 = 1'b0; v8 = 1'b0;
    @(negedge clk);
    model_on = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
